// File: rtl/vrat_ckpt_rename.sv
`default_nettype none
// ============================================================================
// vrat_ckpt_rename: vector register alias table with a circular free list and
// a ring of map checkpoints for single-cycle squash.
// Optional build macro: CELLRV32_VRAT_ERR_EN (sticky protocol-error flag).
// Revision: 1.0
// ============================================================================
module vrat_ckpt_rename #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_REGS  = 64,
    parameter int READ_PORTS = 3,
    parameter int CKPT_DEPTH = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     reconfigure_i,
    output logic                                     busy_o,
    input  logic [READ_PORTS*$clog2(ARCH_REGS)-1:0]  rd_addr_i,
    output logic [READ_PORTS*$clog2(PHYS_REGS)-1:0]  rd_data_o,
    output logic [READ_PORTS-1:0]                    rd_remapped_o,
    input  logic                                     ren_valid_i,
    output logic                                     ren_ready_o,
    input  logic [$clog2(ARCH_REGS)-1:0]             ren_arch_i,
    output logic [$clog2(PHYS_REGS)-1:0]             ren_phys_o,
    output logic [$clog2(PHYS_REGS)-1:0]             ren_old_phys_o,
    input  logic                                     free_valid_i,
    input  logic [$clog2(PHYS_REGS)-1:0]             free_phys_i,
    input  logic                                     ckpt_take_i,
    output logic [$clog2(CKPT_DEPTH)-1:0]            ckpt_id_o,
    output logic                                     ckpt_full_o,
    input  logic                                     ckpt_release_i,
    input  logic                                     restore_i,
    input  logic [$clog2(CKPT_DEPTH)-1:0]            restore_id_i,
    output logic                                     err_o
);

    localparam int AW       = $clog2(ARCH_REGS);
    localparam int PW       = $clog2(PHYS_REGS);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FLW      = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int CNTW     = $clog2(FL_DEPTH + 1);
    localparam int CW       = $clog2(CKPT_DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REINIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [FLW-1:0]         init_idx_q;

    logic [PW-1:0]          map_q [ARCH_REGS];
    logic [ARCH_REGS-1:0]   remapped_q;
    logic [PW-1:0]          fl_q [FL_DEPTH];
    logic [FLW-1:0]         head_q, tail_q;
    logic [CNTW-1:0]        count_q;

    logic [PW-1:0]          ck_map  [CKPT_DEPTH][ARCH_REGS];
    logic [ARCH_REGS-1:0]   ck_rmp  [CKPT_DEPTH];
    logic [FLW-1:0]         ck_head [CKPT_DEPTH];
    logic [CW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW:0]            occ_q;

    logic                   busy, active, start_reinit, init_last;
    logic                   do_restore, ren_fire, free_fire, take_fire, rel_fire;
    logic [FLW-1:0]         saved_head;
    logic [CNTW-1:0]        head_dist;

    function automatic logic [FLW-1:0] fl_inc(input logic [FLW-1:0] p);
        return (p == FLW'(FL_DEPTH - 1)) ? '0 : p + FLW'(1);
    endfunction

    assign busy         = (state_q == REINIT);
    assign busy_o       = busy;
    assign start_reinit = reconfigure_i & ~busy;
    assign active       = ~busy & ~reconfigure_i;
    assign init_last    = (init_idx_q == FLW'(FL_DEPTH - 1));

    assign do_restore   = active & restore_i;
    assign ren_ready_o  = (count_q != '0) & active & ~restore_i;
    assign ren_fire     = ren_valid_i & ren_ready_o;
    assign ckpt_full_o  = (occ_q == (CW+1)'(CKPT_DEPTH));
    assign ckpt_id_o    = wr_ptr_q;
    assign rel_fire     = ckpt_release_i & active & ~restore_i & (occ_q != '0);
    // A coinciding release frees the oldest slot, so a full ring can still take.
    assign take_fire    = ckpt_take_i & active & ~restore_i & (~ckpt_full_o | rel_fire);
`ifdef CELLRV32_VRAT_ERR_EN
    assign free_fire    = free_valid_i & active & (count_q != CNTW'(FL_DEPTH));
`else
    assign free_fire    = free_valid_i & active;
`endif

    assign ren_phys_o     = fl_q[head_q];
    assign ren_old_phys_o = map_q[ren_arch_i];

    // Tags handed out since the checkpoint go back to the free list on restore.
    assign saved_head = ck_head[restore_id_i];
    assign head_dist  = (head_q >= saved_head) ? CNTW'(head_q - saved_head)
                                               : CNTW'(FL_DEPTH) - CNTW'(saved_head - head_q);

    generate
        for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
            assign rd_data_o[g*PW +: PW] = map_q[rd_addr_i[g*AW +: AW]];
            assign rd_remapped_o[g]      = remapped_q[rd_addr_i[g*AW +: AW]];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reconfigure_i) state_d = REINIT;
            REINIT:  if (init_last)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
            for (int k = 0; k < FL_DEPTH; k++)  fl_q[k]  <= PW'(ARCH_REGS + k);
            remapped_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNTW'(FL_DEPTH);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            init_idx_q <= '0;
        end else if (start_reinit) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
            remapped_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            init_idx_q <= '0;
        end else if (busy) begin
            fl_q[init_idx_q] <= PW'(ARCH_REGS) + PW'(init_idx_q);
            init_idx_q       <= init_idx_q + FLW'(1);
            if (init_last) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= CNTW'(FL_DEPTH);
            end
        end else begin
            if (free_fire) begin
                fl_q[tail_q] <= free_phys_i;
                tail_q       <= fl_inc(tail_q);
            end
            if (do_restore) begin
                map_q      <= ck_map[restore_id_i];
                remapped_q <= ck_rmp[restore_id_i];
                head_q     <= saved_head;
                count_q    <= count_q + head_dist + CNTW'(free_fire);
                wr_ptr_q   <= restore_id_i + CW'(1);
                occ_q      <= {1'b0, CW'(restore_id_i - rd_ptr_q)} + (CW+1)'(1);
            end else begin
                if (ren_fire) begin
                    map_q[ren_arch_i]      <= fl_q[head_q];
                    remapped_q[ren_arch_i] <= 1'b1;
                    head_q                 <= fl_inc(head_q);
                end
                count_q  <= count_q + CNTW'(free_fire) - CNTW'(ren_fire);
                if (take_fire) wr_ptr_q <= wr_ptr_q + CW'(1);
                if (rel_fire)  rd_ptr_q <= rd_ptr_q + CW'(1);
                occ_q    <= occ_q + (CW+1)'(take_fire) - (CW+1)'(rel_fire);
            end
        end
    end

    // Snapshot holds start-of-cycle state; a same-cycle rename is younger.
    always_ff @(posedge clk_i) begin
        if (take_fire) begin
            ck_map[wr_ptr_q]  <= map_q;
            ck_rmp[wr_ptr_q]  <= remapped_q;
            ck_head[wr_ptr_q] <= head_q;
        end
    end

`ifdef CELLRV32_VRAT_ERR_EN
    logic        err_q;
    logic        restore_live;
    logic [CW:0] restore_age;

    assign restore_age  = {1'b0, CW'(restore_id_i - rd_ptr_q)};
    assign restore_live = (occ_q != '0) && (restore_age < occ_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if ((free_valid_i & active & (count_q == CNTW'(FL_DEPTH)))
                   | (do_restore & ~restore_live)
                   | (ckpt_release_i & active & ~restore_i & (occ_q == '0))) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vrat_ckpt_rename.sv
`default_nettype none
// ============================================================================
// tb_vrat_ckpt_rename: scoreboard bench for vrat_ckpt_rename.
// Revision: 1.0
// ============================================================================
module tb_vrat_ckpt_rename;

    localparam int AW = 5;
    localparam int PW = 6;
    localparam int CW = 2;

    localparam int S_RD0  = 0;
    localparam int S_RD1  = 1;
    localparam int S_RD2  = 2;
    localparam int S_RMP  = 3;
    localparam int S_BUSY = 4;
    localparam int S_RDY  = 5;
    localparam int S_PHYS = 6;
    localparam int S_OLD  = 7;
    localparam int S_ID   = 8;
    localparam int S_FULL = 9;
    localparam int S_ERR  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              reconfigure;
    logic              busy;
    logic [3*AW-1:0]   rd_addr;
    logic [3*PW-1:0]   rd_data;
    logic [2:0]        rd_remapped;
    logic              ren_valid;
    logic              ren_ready;
    logic [AW-1:0]     ren_arch;
    logic [PW-1:0]     ren_phys;
    logic [PW-1:0]     ren_old_phys;
    logic              free_valid;
    logic [PW-1:0]     free_phys;
    logic              ckpt_take;
    logic [CW-1:0]     ckpt_id;
    logic              ckpt_full;
    logic              ckpt_release;
    logic              restore;
    logic [CW-1:0]     restore_id;
    logic              err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    vrat_ckpt_rename dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .reconfigure_i  (reconfigure),
        .busy_o         (busy),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .rd_remapped_o  (rd_remapped),
        .ren_valid_i    (ren_valid),
        .ren_ready_o    (ren_ready),
        .ren_arch_i     (ren_arch),
        .ren_phys_o     (ren_phys),
        .ren_old_phys_o (ren_old_phys),
        .free_valid_i   (free_valid),
        .free_phys_i    (free_phys),
        .ckpt_take_i    (ckpt_take),
        .ckpt_id_o      (ckpt_id),
        .ckpt_full_o    (ckpt_full),
        .ckpt_release_i (ckpt_release),
        .restore_i      (restore),
        .restore_id_i   (restore_id),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD0:   return 32'(rd_data[0*PW +: PW]);
            S_RD1:   return 32'(rd_data[1*PW +: PW]);
            S_RD2:   return 32'(rd_data[2*PW +: PW]);
            S_RMP:   return 32'(rd_remapped);
            S_BUSY:  return 32'(busy);
            S_RDY:   return 32'(ren_ready);
            S_PHYS:  return 32'(ren_phys);
            S_OLD:   return 32'(ren_old_phys);
            S_ID:    return 32'(ckpt_id);
            S_FULL:  return 32'(ckpt_full);
            S_ERR:   return 32'(err);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic sample();
        exp_t x;
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check_val(x.tag, observe(x.sel), x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr[0*AW +: AW] = AW'(a0);
        rd_addr[1*AW +: AW] = AW'(a1);
        rd_addr[2*AW +: AW] = AW'(a2);
    endtask

    initial begin
        rst = 1'b1; reconfigure = 1'b0; ren_valid = 1'b0; ren_arch = '0;
        free_valid = 1'b0; free_phys = '0; ckpt_take = 1'b0;
        ckpt_release = 1'b0; restore = 1'b0; restore_id = '0;
        set_rd(0, 5, 31);
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        push("rst_rd0", S_RD0, 0);   push("rst_rd1", S_RD1, 5);
        push("rst_rd2", S_RD2, 31);  push("rst_rmp", S_RMP, 0);
        push("rst_busy", S_BUSY, 0); push("rst_rdy", S_RDY, 1);
        push("rst_full", S_FULL, 0); push("rst_id", S_ID, 0);
        push("rst_err", S_ERR, 0);
        sample();

        // First renames of arch 3
        ren_valid = 1'b1; ren_arch = 5'd3;
        push("ren1_phys", S_PHYS, 32); push("ren1_old", S_OLD, 3);
        sample(); tick();
        set_rd(3, 5, 31);
        push("rd3_after", S_RD0, 32); push("rmp3_after", S_RMP, 3'b001);
        push("ren2_phys", S_PHYS, 33); push("ren2_old", S_OLD, 32);
        sample(); tick();

        // Drain the free list
        ren_arch = 5'd10;
        for (int i = 0; i < 30; i++) begin
            push("drain_phys", S_PHYS, 32'(34 + i));
            sample(); tick();
        end
        ren_valid = 1'b0;
        free_valid = 1'b1; free_phys = 6'd3;
        push("empty_rdy", S_RDY, 0);
        sample(); tick();
        free_valid = 1'b0;
        ren_valid = 1'b1; ren_arch = 5'd4;
        push("refill_rdy", S_RDY, 1);
        push("refill_phys", S_PHYS, 3); push("refill_old", S_OLD, 4);
        sample(); tick();
        ren_valid = 1'b0;

        // Reconfigure: 32 busy cycles, rename attempts ignored
        reconfigure = 1'b1;
        push("reconf_busy0", S_BUSY, 0);
        sample(); tick();
        reconfigure = 1'b0;
        ren_valid = 1'b1; ren_arch = 5'd7;
        for (int c = 0; c < 32; c++) begin
            push("reinit_busy", S_BUSY, 1); push("reinit_rdy", S_RDY, 0);
            sample(); tick();
        end
        ren_valid = 1'b0;
        ckpt_take = 1'b1;
        set_rd(3, 10, 4);
        push("post_busy", S_BUSY, 0); push("post_rdy", S_RDY, 1);
        push("post_rd0", S_RD0, 3);   push("post_rd1", S_RD1, 10);
        push("post_rd2", S_RD2, 4);   push("post_rmp", S_RMP, 0);
        push("take0_id", S_ID, 0);    push("take0_full", S_FULL, 0);
        push("post_phys", S_PHYS, 32);
        sample(); tick();

        // Speculative renames then restore to slot 0
        ckpt_take = 1'b0;
        ren_valid = 1'b1; ren_arch = 5'd1;
        push("spec1_phys", S_PHYS, 32); push("spec1_old", S_OLD, 1);
        sample(); tick();
        ren_arch = 5'd2;
        set_rd(1, 2, 0);
        push("spec_rd1", S_RD0, 32); push("spec_rmp", S_RMP, 3'b001);
        push("spec2_phys", S_PHYS, 33); push("spec2_old", S_OLD, 2);
        sample(); tick();
        ren_valid = 1'b0;
        restore = 1'b1; restore_id = 2'd0;
        push("rst_blk_rdy", S_RDY, 0);
        push("pre_rest_rd2", S_RD1, 33);
        sample(); tick();
        restore = 1'b0;
        ren_valid = 1'b1; ren_arch = 5'd5;
        push("rest_rd1", S_RD0, 1); push("rest_rd2", S_RD1, 2);
        push("rest_rmp", S_RMP, 0);
        push("rest_phys", S_PHYS, 32); push("rest_old", S_OLD, 5);
        sample(); tick();
        ren_valid = 1'b0;

        // Fill the ring
        ckpt_take = 1'b1;
        for (int t = 1; t < 4; t++) begin
            push("take_id", S_ID, 32'(t)); push("take_full", S_FULL, 0);
            sample(); tick();
        end
        push("full_set", S_FULL, 1); push("full_id", S_ID, 0);
        sample(); tick();
        ckpt_release = 1'b1;
        push("full_ignored", S_FULL, 1); push("full_ignored_id", S_ID, 0);
        sample(); tick();
        ckpt_take = 1'b0; ckpt_release = 1'b0;
        push("relt_full", S_FULL, 1); push("relt_id", S_ID, 1);
        sample(); tick();

        // Restore into the middle of the ring
        restore = 1'b1; restore_id = 2'd2;
        sample(); tick();
        restore = 1'b0;
        set_rd(5, 1, 2);
        ren_valid = 1'b1; ren_arch = 5'd6;
        push("mid_id", S_ID, 3);      push("mid_full", S_FULL, 0);
        push("mid_rd5", S_RD0, 32);   push("mid_rd1", S_RD1, 1);
        push("mid_rmp", S_RMP, 3'b001);
        push("mid_phys", S_PHYS, 33); push("mid_old", S_OLD, 6);
        sample(); tick();
        ren_valid = 1'b0;

`ifdef CELLRV32_VRAT_ERR_EN
        reconfigure = 1'b1;
        tick();
        reconfigure = 1'b0;
        repeat (32) tick();
        free_valid = 1'b1; free_phys = 6'd5;
        push("err_before", S_ERR, 0);
        sample(); tick();
        free_valid = 1'b0;
        push("err_after", S_ERR, 1);
        sample();
`else
        push("err_tied", S_ERR, 0);
        sample();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
